// File: rtl/divider_pkg.sv
// Shared definitions for the 16-bit restoring divider slice.
// Holds the FSM state encoding, datapath width, step count and counter width.
// Imported by the interface, the subtractor and the divider top.
package divider_pkg;

   localparam int DIV_W     = 16;
   localparam int DIV_STEPS = 16;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/divider_16_bit_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
// Latency: none, wires only.
// Backpressure: none; start is a request pulse, done a one-cycle result strobe.
// Ports: start/X/Y driven by master; busy/done/Q/R/div_by_zero driven by slave.
interface divider_16_bit_if;
   import divider_pkg::*;

   logic             start;
   logic [DIV_W-1:0] X;
   logic [DIV_W-1:0] Y;
   logic             busy;
   logic             done;
   logic [DIV_W-1:0] Q;
   logic [DIV_W-1:0] R;
   logic             div_by_zero;

   modport master (
      output start, X, Y,
      input  busy, done, Q, R, div_by_zero
   );

   modport slave (
      input  start, X, Y,
      output busy, done, Q, R, div_by_zero
   );

endinterface

// File: rtl/subtractor_16_bit.sv
// 16-bit unsigned subtractor: Z[15:0] = A - B (mod 2^16), Z[16] = borrow out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: A, B operands in; Z {borrow, difference} out.
module subtractor_16_bit
   import divider_pkg::*;
(
   input  logic [DIV_W-1:0] A,
   input  logic [DIV_W-1:0] B,
   output logic [DIV_W:0]   Z
);

   // Borrow-in is not used by any client, so it is fixed at zero here.
   logic b_in;
   assign b_in = 1'b0;

   // Zero-extending both operands makes bit 16 of the result the borrow.
   assign Z = {1'b0, A} - {1'b0, B} - {{DIV_W{1'b0}}, b_in};

endmodule

// File: rtl/divider_16_bit.sv
// Sequential 16-bit unsigned restoring divider, one trial subtraction per clock.
// Latency: done exactly 17 cycles after start is sampled, operand independent.
// Backpressure: none; start during RUN is ignored, start in DONE chains back-to-back.
// Ports: clk, rst (async active-high); bus = slave side of divider_16_bit_if.
module divider_16_bit
   import divider_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   divider_16_bit_if.slave   bus
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [DIV_W-1:0] p_q,     p_d;
   logic [DIV_W-1:0] qs_q,    qs_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [DIV_W-1:0] q_q,     q_d;
   logic [DIV_W-1:0] r_q,     r_d;
   logic             dbz_q,   dbz_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             msb;
   logic [DIV_W-1:0] p_shift;
   logic [DIV_W:0]   sub_z;
   logic             step_ok;
   logic [DIV_W-1:0] p_step;
   logic [DIV_W-1:0] qs_step;

   // Shift {P,Qs} left by one; the bit leaving P[15] is kept as msb.
   assign msb     = p_q[DIV_W-1];
   assign p_shift = {p_q[DIV_W-2:0], qs_q[DIV_W-1]};

   subtractor_16_bit u_sub (
      .A (p_shift),
      .B (div_q),
      .Z (sub_z)
   );

   // With msb set the true partial remainder is >= 2^16 > divisor, so the
   // step succeeds and the mod-2^16 difference is already the right value.
   assign step_ok = msb | ~sub_z[DIV_W];
   assign p_step  = step_ok ? sub_z[DIV_W-1:0] : p_shift;
   assign qs_step = {qs_q[DIV_W-2:0], step_ok};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      qs_d    = qs_q;
      div_d   = div_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               div_d   = bus.Y;
               qs_d    = bus.X;
               p_d     = '0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            p_d   = p_step;
            qs_d  = qs_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
               state_d = ST_DONE;
               q_d     = qs_step;
               r_d     = p_step;
               // Divide by zero needs no special path: every step succeeds,
               // giving Q = all ones and R = X; only the flag is extra.
               dbz_d   = (div_q == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered, decoded from the next state.
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         qs_q    <= '0;
         div_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         qs_q    <= qs_d;
         div_q   <= div_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.Q           = q_q;
   assign bus.R           = r_q;
   assign bus.div_by_zero = dbz_q;

endmodule
